// File: rtl/fm_modulator.sv
// fm_modulator: baseband FM modulator, clk/reset/clk_enable/in_msg (ufix13_En12) in, out_I/out_Q (sfix39_En36)/out_valid/ce_out out, 19-cycle CORDIC pipeline
module fm_modulator #(
  parameter int PHASE_W = 24,
  parameter logic [PHASE_W-1:0] FC_WORD = '0,
  parameter logic [19:0] KF_WORD = 20'h10000,
  parameter int AMP = 196608
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic [12:0]        in_msg,
  output logic signed [38:0] out_I,
  output logic signed [38:0] out_Q,
  output logic               out_valid,
  output logic               ce_out
);
  localparam logic [4:0] LAT = 5'd19;
  localparam logic signed [20:0] X0 = 21'((64'(AMP) * 64'd39797) >> 16);
  localparam logic signed [15:0] ATAN [16] = '{
    16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326, 16'sd163, 16'sd81,
    16'sd41, 16'sd20, 16'sd10, 16'sd5, 16'sd3, 16'sd1, 16'sd1, 16'sd0
  };
  logic signed [13:0] m;
  logic signed [34:0] prod;
  logic [PHASE_W-1:0] fcw_q, fcw_d, phase_q, phase_d;
  logic [15:0] p;
  logic signed [20:0] x_q [17];
  logic signed [20:0] x_d [17];
  logic signed [20:0] y_q [17];
  logic signed [20:0] y_d [17];
  logic signed [15:0] z_q [16];
  logic signed [15:0] z_d [16];
  logic signed [38:0] i_q, i_d, q_q, q_d;
  logic [4:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  assign m = $signed({1'b0, in_msg}) - 14'sd4096;
  assign prod = 35'(m) * 35'($signed({1'b0, KF_WORD}));
  assign fcw_d = FC_WORD + PHASE_W'(prod >>> 12);
  assign phase_d = phase_q + fcw_q;
  assign p = phase_q[PHASE_W-1 -: 16];
  assign x_d[0] = p[15:14] == 2'd0 ? X0 : p[15:14] == 2'd2 ? -X0 : '0;
  assign y_d[0] = p[15:14] == 2'd1 ? X0 : p[15:14] == 2'd3 ? -X0 : '0;
  assign z_d[0] = $signed({2'b00, p[13:0]});
  for (genvar i = 0; i < 16; i++) begin : g_c
    assign x_d[i+1] = z_q[i][15] ? x_q[i] + (y_q[i] >>> i) : x_q[i] - (y_q[i] >>> i);
    assign y_d[i+1] = z_q[i][15] ? y_q[i] - (x_q[i] >>> i) : y_q[i] + (x_q[i] >>> i);
    if (i < 15) begin : g_z
      assign z_d[i+1] = z_q[i][15] ? z_q[i] + ATAN[i] : z_q[i] - ATAN[i];
    end
  end
  assign i_d = {x_q[16], 18'd0};
  assign q_d = {y_q[16], 18'd0};
  assign cnt_d = cnt_q == LAT ? cnt_q : cnt_q + 5'd1;
  assign valid_d = cnt_d == LAT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcw_q <= '0;
      phase_q <= '0;
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      z_q <= '{default: '0};
      i_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else if (clk_enable) begin
      fcw_q <= fcw_d;
      phase_q <= phase_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign out_I = i_q;
  assign out_Q = q_q;
  assign out_valid = valid_q;
  assign ce_out = clk_enable;
endmodule

// File: tb/tb_fm_modulator.sv
// tb_fm_modulator: scoreboard bench for fm_modulator, three parameterisations sharing one stimulus stream
module tb_fm_modulator;
  typedef struct packed {
    logic [2:0][38:0] ei;
    logic [2:0][38:0] eq;
    logic [2:0][23:0] ph;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_enable = 1'b0;
  logic [12:0] in_msg = 13'h1000;
  logic signed [38:0] oi [3];
  logic signed [38:0] oq [3];
  logic ov [3];
  logic ce [3];
  longint fc_m [3] = '{0, 64'h400000, 0};
  longint kf_m [3] = '{64'h10000, 64'h10000, 64'hFFFFF};
  longint amp_m [3] = '{196608, 196608, 229375};
  longint atan_t [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
  longint acc [3];
  exp_t sb [$];
  exp_t last;
  int vcnt = 0;
  int checks = 0;
  int errors = 0;
  int n;
  always #5 clk = ~clk;
  fm_modulator #(.FC_WORD(24'h000000), .KF_WORD(20'h10000), .AMP(196608)) u0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_msg(in_msg),
    .out_I(oi[0]), .out_Q(oq[0]), .out_valid(ov[0]), .ce_out(ce[0]));
  fm_modulator #(.FC_WORD(24'h400000), .KF_WORD(20'h10000), .AMP(196608)) u1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_msg(in_msg),
    .out_I(oi[1]), .out_Q(oq[1]), .out_valid(ov[1]), .ce_out(ce[1]));
  fm_modulator #(.FC_WORD(24'h000000), .KF_WORD(20'hFFFFF), .AMP(229375)) u2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_msg(in_msg),
    .out_I(oi[2]), .out_Q(oq[2]), .out_valid(ov[2]), .ce_out(ce[2]));
  function automatic longint fcw_of(input int k, input logic [12:0] msg);
    longint mm;
    mm = longint'(msg) - 4096;
    return (fc_m[k] + ((mm * kf_m[k]) >>> 12)) & 64'hFFFFFF;
  endfunction
  function automatic void cordic(input logic [23:0] ph, input longint amp, output longint xo, output longint yo);
    longint x, y, z, x0, t, pp, q;
    x0 = (amp * 39797) >>> 16;
    pp = longint'(ph[23:8]);
    q = pp / 16384;
    z = pp - q * 16384;
    x = q == 0 ? x0 : q == 2 ? -x0 : 0;
    y = q == 1 ? x0 : q == 3 ? -x0 : 0;
    for (int i = 0; i < 16; i++) begin
      t = x;
      if (z >= 0) begin
        x = x - (y >>> i);
        y = y + (t >>> i);
        z = z - atan_t[i];
      end else begin
        x = x + (y >>> i);
        y = y - (t >>> i);
        z = z + atan_t[i];
      end
    end
    xo = x;
    yo = y;
  endfunction
  task automatic chk(input string nm, input int k, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", nm, k, got, exp, $time);
    end
  endtask
  task automatic near(input string nm, input int k, input real got, input real exp);
    checks++;
    if ((got - exp > 256.0 * 262144.0) || (exp - got > 256.0 * 262144.0)) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0f expected=%0f t=%0t", nm, k, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin : push
    exp_t e;
    longint x, y;
    if (reset) begin
      sb.delete();
      for (int k = 0; k < 3; k++) acc[k] = 0;
    end else if (clk_enable) begin
      for (int k = 0; k < 3; k++) begin
        cordic(acc[k][23:0], amp_m[k], x, y);
        e.ei[k] = 39'(x * 262144);
        e.eq[k] = 39'(y * 262144);
        e.ph[k] = acc[k][23:0];
        acc[k] = (acc[k] + fcw_of(k, in_msg)) & 64'hFFFFFF;
      end
      sb.push_back(e);
    end
  end
  always @(posedge clk) begin : monitor
    logic en_s, rs_s;
    real th;
    en_s = clk_enable;
    rs_s = reset;
    #2;
    for (int k = 0; k < 3; k++) chk("ce_out", k, longint'(ce[k]), longint'(clk_enable));
    if (rs_s || reset) begin
      vcnt = 0;
      last = '0;
    end else begin
      if (en_s) vcnt = vcnt == 19 ? 19 : vcnt + 1;
      for (int k = 0; k < 3; k++) chk("out_valid", k, longint'(ov[k]), longint'(vcnt == 19));
      if (en_s && vcnt == 19) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty got=0 expected>0 t=%0t", $time);
        end else begin
          last = sb.pop_front();
          for (int k = 0; k < 3; k++) begin
            chk("out_I", k, longint'(oi[k]), longint'($signed(last.ei[k])));
            chk("out_Q", k, longint'(oq[k]), longint'($signed(last.eq[k])));
            th = 2.0 * 3.14159265358979 * real'(last.ph[k]) / 16777216.0;
            near("out_I_cos", k, real'(oi[k]), real'(amp_m[k]) * 262144.0 * $cos(th));
            near("out_Q_sin", k, real'(oq[k]), real'(amp_m[k]) * 262144.0 * $sin(th));
          end
        end
      end else if (!en_s && vcnt == 19) begin
        for (int k = 0; k < 3; k++) begin
          chk("hold_I", k, longint'(oi[k]), longint'($signed(last.ei[k])));
          chk("hold_Q", k, longint'(oq[k]), longint'($signed(last.eq[k])));
        end
      end
    end
  end
  task automatic drive(input logic en, input logic [12:0] msg);
    @(posedge clk);
    #1;
    clk_enable = en;
    in_msg = msg;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_rst_I", k, longint'(oi[k]), 0);
      chk("async_rst_Q", k, longint'(oq[k]), 0);
      chk("async_rst_valid", k, longint'(ov[k]), 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_I", k, longint'(oi[k]), 0);
      chk("rst_Q", k, longint'(oq[k]), 0);
      chk("rst_valid", k, longint'(ov[k]), 0);
    end
    reset = 1'b0;
    clk_enable = 1'b1;
    in_msg = 13'h1000;
    repeat (29) drive(1'b1, 13'h1000);
    repeat (40) drive(1'b1, 13'h1400);
    repeat (40) drive(1'b1, 13'h0C00);
    repeat (10) drive(1'b1, 13'h0000);
    repeat (10) drive(1'b1, 13'h1FFF);
    n = 0;
    while (n < 200) begin
      drive(1'b1, 13'($urandom));
      n++;
      if (n == 57) do_reset();
      drive(1'b0, in_msg);
      drive(1'b0, in_msg);
    end
    repeat (60) drive(1'b1, 13'($urandom));
    repeat (25) drive(1'b1, 13'h1000);
    drive(1'b0, 13'h1000);
    repeat (3) @(posedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
